ws_inst_seq: RTL

- Hardware instruction sequencer that generates the 39-bit instruction word consumed by the core, replacing testbench-driven instruction streams.
- Runs one weight-stationary tile per start pulse: weights into L0, kernel load into the PE array, activations into L0, execute, then drain OFIFO into psum SRAM.
- Sits between the host/config registers and the core's inst input; observes the core's ofifo_valid.

---
 rtl/ws_inst_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ws_inst_seq.sv
// Weight-stationary instruction sequencer: one tile per start pulse.
// The tile runs weight load, kernel load, activation load, execute, then OFIFO drain into psum SRAM.
module ws_inst_seq #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned inst_bw = 39,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned CNT_W   = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               relu_en,
    input  logic [ADDR_W-1:0]  w_base,
    input  logic [ADDR_W-1:0]  x_base,
    input  logic [ADDR_W-1:0]  p_base,
    input  logic [CNT_W-1:0]   n_act,
    input  logic               ofifo_valid,
    output logic [inst_bw-1:0] inst,
    output logic               busy,
    output logic               done
);

    // Phase counter must cover both row+col and n_act+1 words
    localparam int unsigned CW = CNT_W + 1;

    localparam int unsigned B_RELU    = 37;
    localparam int unsigned B_LDMODE  = 35;
    localparam int unsigned B_CEN_P   = 32;
    localparam int unsigned B_WEN_P   = 31;
    localparam int unsigned B_A_P     = 20;
    localparam int unsigned B_CEN_X   = 19;
    localparam int unsigned B_A_X     = 7;
    localparam int unsigned B_OFIFO_RD = 6;
    localparam int unsigned B_L0_RD   = 3;
    localparam int unsigned B_L0_WR   = 2;
    localparam int unsigned B_EXEC    = 1;
    localparam int unsigned B_KFLUSH  = 0;

    localparam logic [inst_bw-1:0] IDLE_WORD = inst_bw'(39'h1_800C_0000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_KLOAD,
        S_XLOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               wr_pend_q, wr_pend_d;
    logic               ov_q;
    logic               relu_q, relu_d;
    logic [ADDR_W-1:0]  w_base_q, w_base_d;
    logic [ADDR_W-1:0]  x_base_q, x_base_d;
    logic [ADDR_W-1:0]  p_base_q, p_base_d;
    logic [CNT_W-1:0]   n_act_q, n_act_d;
    logic [inst_bw-1:0] inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [inst_bw-1:0] job_word;
    logic               rd_go;

    // Next-state and next-instruction word from the current state/counters
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_pend_d = wr_pend_q;
        relu_d    = relu_q;
        w_base_d  = w_base_q;
        x_base_d  = x_base_q;
        p_base_d  = p_base_q;
        n_act_d   = n_act_q;
        inst_d    = IDLE_WORD;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_go     = 1'b0;
        job_word  = IDLE_WORD;
        job_word[B_RELU] = relu_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    relu_d   = relu_en;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    p_base_d = p_base;
                    n_act_d  = n_act;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_WLOAD;
                end
            end

            S_WLOAD: begin
                inst_d = job_word;
                if (cnt_q < CW'(row)) begin
                    inst_d[B_CEN_X]          = 1'b0;
                    inst_d[B_A_X +: ADDR_W]  = w_base_q + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    inst_d[B_L0_WR] = 1'b1;
                end
                if (cnt_q == CW'(row)) begin
                    cnt_d   = '0;
                    state_d = S_KLOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_KLOAD: begin
                inst_d            = job_word;
                inst_d[B_L0_RD]   = 1'b1;
                inst_d[B_LDMODE]  = 1'b1;
                if (cnt_q == CW'(row + col - 1)) begin
                    inst_d[B_KFLUSH] = 1'b1;
                    cnt_d            = '0;
                    state_d          = (n_act_q == '0) ? S_DONE : S_XLOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_XLOAD: begin
                inst_d = job_word;
                if (cnt_q < CW'(n_act_q)) begin
                    inst_d[B_CEN_X]          = 1'b0;
                    inst_d[B_A_X +: ADDR_W]  = x_base_q + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    inst_d[B_L0_WR] = 1'b1;
                end
                if (cnt_q == CW'(n_act_q)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_EXEC: begin
                inst_d          = job_word;
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_EXEC]  = 1'b1;
                if (cnt_q + CW'(1) == CW'(n_act_q)) begin
                    cnt_d     = '0;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    wr_pend_d = 1'b0;
                    state_d   = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DRAIN: begin
                // A read is only stalled by ofifo_valid; the write owed by the previous read always goes out
                inst_d = job_word;
                rd_go  = ov_q && (rd_cnt_q != n_act_q);
                inst_d[B_OFIFO_RD] = rd_go;
                if (wr_pend_q) begin
                    inst_d[B_CEN_P]         = 1'b0;
                    inst_d[B_WEN_P]         = 1'b0;
                    inst_d[B_A_P +: ADDR_W] = p_base_q + ADDR_W'(wr_cnt_q);
                    wr_cnt_d                = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q + CNT_W'(1) == n_act_q) begin
                        state_d = S_DONE;
                    end
                end
                wr_pend_d = rd_go;
                rd_cnt_d  = rd_cnt_q + CNT_W'(rd_go);
            end

            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            ov_q      <= 1'b0;
            relu_q    <= 1'b0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            p_base_q  <= '0;
            n_act_q   <= '0;
            inst_q    <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            ov_q      <= ofifo_valid;
            relu_q    <= relu_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            p_base_q  <= p_base_d;
            n_act_q   <= n_act_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
